// File: rtl/bitmap_pixel_writer.sv
// Read-modify-write front end for a 1-bit-per-pixel bitmap held in a single-port
// synchronous block RAM: pixel clear/set/toggle plus a whole-bitmap clear.
module bitmap_pixel_writer #(
    parameter int DW = 8,
    parameter int AW = 10,
    parameter int XW = 7,
    parameter int YW = 6
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [XW-1:0] req_x,
    input  logic [YW-1:0] req_y,
    output logic          done,
    output logic          pix_old,
    output logic          busy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int BW = $clog2(DW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_CLR  = 2'd3;

    localparam logic [1:0] OP_CLR_PIX = 2'b00;
    localparam logic [1:0] OP_SET_PIX = 2'b01;
    localparam logic [1:0] OP_TGL_PIX = 2'b10;
    localparam logic [1:0] OP_CLR_ALL = 2'b11;

    logic [1:0]    state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic          done_q, done_d;
    logic          pix_old_q, pix_old_d;
    logic          busy_q, busy_d;
    logic          accept_s;

    function automatic logic [DW-1:0] apply_op(input logic [DW-1:0] word,
                                               input logic [BW-1:0] idx,
                                               input logic [1:0]    op);
        logic [DW-1:0] mask;
        mask = {{(DW-1){1'b0}}, 1'b1} << idx;
        case (op)
            OP_CLR_PIX: apply_op = word & ~mask;
            OP_SET_PIX: apply_op = word | mask;
            OP_TGL_PIX: apply_op = word ^ mask;
            default:    apply_op = word;
        endcase
    endfunction

    assign req_ready = (state_q == S_IDLE) && rstn;
    assign accept_s  = req_valid && req_ready;

    // Next-state and next-output computation for the command sequencer.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        bit_d     = bit_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        done_d    = 1'b0;
        pix_old_d = pix_old_q;
        busy_d    = busy_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    op_d   = req_op;
                    bit_d  = req_x[BW-1:0];
                    busy_d = 1'b1;
                    if (req_op == OP_CLR_ALL) begin
                        state_d = S_CLR;
                        cnt_d   = {AW{1'b0}};
                        addr_d  = {AW{1'b0}};
                        we_d    = 1'b1;
                    end else begin
                        state_d = S_RD;
                        addr_d  = {req_y, req_x[XW-1:BW]};
                        we_d    = 1'b0;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_RD: begin
                state_d = S_WR;
                we_d    = 1'b1;
            end
            S_WR: begin
                state_d   = S_IDLE;
                we_d      = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                pix_old_d = ram_dout[bit_q];
            end
            S_CLR: begin
                // Stop exactly on the last address; the counter never wraps.
                if (cnt_q == {AW{1'b1}}) begin
                    state_d   = S_IDLE;
                    we_d      = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    pix_old_d = 1'b0;
                    cnt_d     = {AW{1'b0}};
                    addr_d    = {AW{1'b0}};
                end else begin
                    cnt_d  = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                    addr_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = S_IDLE;
                we_d    = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Write data is the freshly read word with the target bit modified; the RAM
    // only presents the old word during WR, so this path starts at ram_dout.
    always_comb begin
        if (state_q == S_WR) begin
            ram_din = apply_op(ram_dout, bit_q, op_q);
        end else begin
            ram_din = {DW{1'b0}};
        end
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            op_q      <= 2'b00;
            bit_q     <= {BW{1'b0}};
            cnt_q     <= {AW{1'b0}};
            addr_q    <= {AW{1'b0}};
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            pix_old_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            done_q    <= done_d;
            pix_old_q <= pix_old_d;
            busy_q    <= busy_d;
        end
    end

    assign ram_addr = addr_q;
    assign ram_we   = we_q;
    assign done     = done_q;
    assign pix_old  = pix_old_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_bitmap_pixel_writer.sv
// Directed bench for bitmap_pixel_writer with a behavioural synchronous RAM.
module tb_bitmap_pixel_writer;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_op = 2'b00;
    logic [6:0] req_x = 7'd0;
    logic [5:0] req_y = 6'd0;
    logic       done, pix_old, busy;
    logic [9:0] ram_addr;
    logic       ram_we;
    logic [7:0] ram_din;
    logic [7:0] ram_dout;

    logic [7:0] mem [1024];
    logic       bd_fill = 1'b0;
    logic       bd_we = 1'b0;
    logic [9:0] bd_addr = 10'd0;
    logic [7:0] bd_data = 8'd0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bitmap_pixel_writer dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_x(req_x), .req_y(req_y),
        .done(done), .pix_old(pix_old), .busy(busy),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port RAM with a bench backdoor for preloading.
    always @(posedge clk) begin
        if (bd_fill) begin
            for (int i = 0; i < 1024; i++) mem[i] <= bd_data;
        end else if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
        ram_dout <= mem[ram_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic fill_mem(input logic [7:0] val);
        @(negedge clk); bd_fill = 1'b1; bd_data = val;
        @(negedge clk); bd_fill = 1'b0;
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] val);
        @(negedge clk); bd_we = 1'b1; bd_addr = a; bd_data = val;
        @(negedge clk); bd_we = 1'b0;
    endtask

    task automatic do_pix(input logic [1:0] op, input logic [6:0] x, input logic [5:0] y,
                          input logic [9:0] exp_addr, input logic [7:0] exp_word, input logic exp_old);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_x = x; req_y = y;
        check_eq("pix_ready_idle", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("pix_rd", {busy, req_ready, ram_we, done, ram_addr}, {1'b1, 1'b0, 1'b0, 1'b0, exp_addr});
        @(posedge clk); #1;
        check_eq("pix_wr", {ram_we, ram_addr, ram_din, done, req_ready}, {1'b1, exp_addr, exp_word, 1'b0, 1'b0});
        @(posedge clk); #1;
        check_eq("pix_done", {done, pix_old, busy, ram_we, req_ready}, {1'b1, exp_old, 1'b0, 1'b0, 1'b1});
        check_eq("pix_mem", {24'd0, mem[exp_addr]}, {24'd0, exp_word});
        @(posedge clk); #1;
        check_eq("pix_done_pulse", {31'd0, done}, 32'd0);
    endtask

    // Back-to-back sequence on word 80 (y=5, x<8): op, x, expected word, expected old bit.
    logic [1:0] b2b_op  [10] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2};
    logic [2:0] b2b_x   [10] = '{3'd0, 3'd1, 3'd0, 3'd7, 3'd7, 3'd1, 3'd3, 3'd3, 3'd4, 3'd2};
    logic [7:0] b2b_w   [10] = '{8'h01, 8'h03, 8'h02, 8'h82, 8'h02, 8'h00, 8'h08, 8'h00, 8'h10, 8'h14};
    logic       b2b_old [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bad_lo, bad_hi, waits, prev_acc;

        // Reset with an all-zero bitmap.
        fill_mem(8'h00);
        #1;
        check_eq("reset_outs", {done, pix_old, busy, ram_we, req_ready, ram_addr, ram_din},
                 {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0});
        @(negedge clk); rstn = 1'b1;
        #1;
        check_eq("reset_ready", {31'd0, req_ready}, 32'd1);

        do_pix(2'b01, 7'd10, 6'd3, 10'd49, 8'h04, 1'b0);
        do_pix(2'b01, 7'd15, 6'd3, 10'd49, 8'h84, 1'b0);
        do_pix(2'b10, 7'd10, 6'd3, 10'd49, 8'h80, 1'b1);
        do_pix(2'b00, 7'd15, 6'd3, 10'd49, 8'h00, 1'b1);

        // Whole-bitmap clear with non-zero words at both ends.
        poke(10'd0, 8'hFF);
        poke(10'd1023, 8'hAA);
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b11; req_x = 7'd5; req_y = 6'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            check_eq("clr_seq", {13'd0, busy, done, ram_we, ram_addr, ram_din},
                     {13'd0, 1'b1, 1'b0, 1'b1, i[9:0], 8'h00});
            @(posedge clk); #1;
        end
        check_eq("clr_done", {done, pix_old, busy, ram_we, req_ready}, {1'b1, 1'b0, 1'b0, 1'b0, 1'b1});
        bad_lo = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== 8'h00) bad_lo++;
        check_eq("clr_all_zero", bad_lo, 32'd0);
        @(posedge clk); #1;
        check_eq("clr_done_pulse", {31'd0, done}, 32'd0);

        // Requester holds valid high; each command is accepted once every 3 cycles.
        prev_acc = -1;
        @(negedge clk);
        req_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            req_op = b2b_op[k]; req_x = {4'd0, b2b_x[k]}; req_y = 6'd5;
            waits = 0;
            while (!req_ready && waits < 10) begin
                @(negedge clk);
                waits++;
            end
            check_eq("b2b_ready_wait", waits, 32'd0);
            @(posedge clk); #1;
            check_eq("b2b_accept", {31'd0, busy}, 32'd1);
            if (prev_acc >= 0) check_eq("b2b_gap", cyc - prev_acc, 32'd3);
            prev_acc = cyc;
            @(posedge clk); #1;
            check_eq("b2b_wr", {done, ram_we, ram_addr, ram_din}, {1'b0, 1'b1, 10'd80, b2b_w[k]});
            @(posedge clk); #1;
            check_eq("b2b_done", {done, pix_old}, {1'b1, b2b_old[k]});
            check_eq("b2b_mem", {24'd0, mem[80]}, {24'd0, b2b_w[k]});
            @(negedge clk);
        end
        req_valid = 1'b0;

        // Asynchronous reset in the middle of a clear.
        fill_mem(8'h5A);
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b11;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        check_eq("mid_clr_addr", {22'd0, ram_we, ram_addr}, {22'd0, 1'b1, 10'd500});
        #1;
        rstn = 1'b0;
        #1;
        check_eq("mid_clr_rst", {done, busy, ram_we, req_ready, ram_addr, ram_din},
                 {1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0});
        repeat (2) @(posedge clk);
        @(negedge clk); rstn = 1'b1;
        #1;
        check_eq("mid_clr_ready", {31'd0, req_ready}, 32'd1);
        bad_lo = 0; bad_hi = 0;
        for (int i = 0; i < 500; i++) if (mem[i] !== 8'h00) bad_lo++;
        for (int i = 500; i < 1024; i++) if (mem[i] !== 8'h5A) bad_hi++;
        check_eq("mid_clr_lo_zero", bad_lo, 32'd0);
        check_eq("mid_clr_hi_kept", bad_hi, 32'd0);

        // Reset during RD of a pixel set: no write, no done.
        poke(10'd0, 8'h40);
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'b01; req_x = 7'd0; req_y = 6'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check_eq("rd_rst_inrd", {31'd0, busy}, 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("rd_rst_outs", {done, busy, ram_we}, 32'd0);
        bad_lo = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done !== 1'b0) bad_lo++;
        end
        @(negedge clk); rstn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || ram_we !== 1'b0) bad_lo++;
        end
        check_eq("rd_rst_no_done", bad_lo, 32'd0);
        check_eq("rd_rst_mem", {24'd0, mem[0]}, 32'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
